// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and UART TX byte handshakes shared by the arbiter
// master is the arbiter side; slave is the requesters plus the UART core.
interface uart_tx_arbiter_if #(
   parameter int NREQ = 2,
   parameter int DW   = 8
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    req_last;
   logic [NREQ-1:0]    req_ready;
   logic               tx_valid;
   logic [DW-1:0]      tx_data;
   logic               tx_ready;

   modport master (
      input  req_valid, req_data, req_last, tx_ready,
      output req_ready, tx_valid, tx_data
   );

   modport slave (
      output req_valid, req_data, req_last, tx_ready,
      input  req_ready, tx_valid, tx_data
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, message-granular arbiter for the UART TX byte stream
// A grant lasts until the holder's last byte or until the idle timeout revokes it.
module uart_tx_arbiter #(
   parameter int NREQ    = 2,
   parameter int DW      = 8,
   parameter int TIMEOUT = 1024
) (
   input  logic                    clkin,
   input  logic                    reset,
   uart_tx_arbiter_if.master       bus,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic                    busy,
   output logic                    timeout_pulse
);
   localparam int GW = $clog2(NREQ);
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t        state;
   logic [CW-1:0] idle_cnt;
   logic [GW-1:0] winner;
   logic          xfer;
   logic          xfer_last;

   // Search starts one past the previous grant so the last holder has lowest priority.
   always_comb begin
      int idx;
      idx    = 0;
      winner = grant_id;
      for (int i = NREQ; i >= 1; i--) begin
         idx = (int'(grant_id) + i) % NREQ;
         if (bus.req_valid[idx]) winner = GW'(idx);
      end
   end

   always_comb begin
      bus.tx_valid  = 1'b0;
      bus.tx_data   = '0;
      bus.req_ready = '0;
      if (state == GRANT) begin
         bus.tx_valid            = bus.req_valid[grant_id];
         bus.tx_data             = bus.req_data[grant_id*DW +: DW];
         bus.req_ready[grant_id] = bus.tx_ready;
      end
   end

   assign xfer      = (state == GRANT) && bus.req_valid[grant_id] && bus.tx_ready;
   assign xfer_last = xfer && bus.req_last[grant_id];
   assign busy      = (state == GRANT);

   always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         grant_id      <= GW'(NREQ - 1);
         idle_cnt      <= '0;
         timeout_pulse <= 1'b0;
      end else begin
         timeout_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (|bus.req_valid) begin
                  grant_id <= winner;
                  idle_cnt <= '0;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               if (xfer) begin
                  idle_cnt <= '0;
                  if (xfer_last) state <= IDLE;
               end else if (TIMEOUT > 0 && idle_cnt == LIMIT) begin
                  // The partial message is abandoned; nothing is sent to close it.
                  idle_cnt      <= '0;
                  timeout_pulse <= 1'b1;
                  state         <= IDLE;
               end else if (idle_cnt != '1) begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single system UART transmit byte stream between NREQ independent byte-stream requesters, e.g. a fabric debug/status logger alongside the processor console path.
- Uses round-robin arbitration with message granularity: a grant is held until the requester's last byte, so lines from different sources never interleave.
- An idle timeout revokes a stalled grant.
- Sits between the requesters and the UART core's byte-wide valid/ready TX interface, in the clkin domain.

Parameters:
- NREQ, 2, number of requesters (2..8).
- DW, 8, byte width of the data path.
- TIMEOUT, 1024, cycles of granted-but-idle before forced release; 0 disables the timeout.

Ports:
- clkin  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester byte valid.
- req_data  in  NREQ*DW  per-requester byte; requester i occupies bits [i*DW +: DW].
- req_last  in  NREQ  marks the final byte of a message; qualified by req_valid.
- req_ready  out  NREQ  per-requester accept.
- tx_valid  out  1  byte valid to the UART core.
- tx_data  out  DW  byte to the UART core.
- tx_ready  in  1  UART core accept.
- grant_id  out  $clog2(NREQ)  current or most recent granted requester.
- busy  out  1  high while in GRANT.
- timeout_pulse  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset values (asynchronous):
  - state=IDLE, grant_id=NREQ-1, so requester 0 wins first.
  - Idle counter=0.
  - busy=0, timeout_pulse=0, tx_valid=0, req_ready=0, tx_data=0.
- States: IDLE, GRANT.
- IDLE:
  - When any req_valid is high, select the first set bit searching grant_id+1, grant_id+2, … modulo NREQ.
  - Register the winner into grant_id and move to GRANT on the next edge, giving 1 cycle of arbitration latency.
  - No transfers occur in IDLE.
- GRANT, with g = grant_id:
  - tx_valid = req_valid[g] and tx_data = req_data[g], combinational.
  - req_ready[g] = tx_ready; all other req_ready bits are 0.
  - A transfer is a cycle with req_valid[g] and tx_ready both high.
- Release: a transfer with req_last[g]=1 returns the arbiter to IDLE on that edge, and the idle counter clears.
  - The next grant therefore begins no earlier than 1 cycle later.
  - A back-to-back message from the same requester re-arbitrates, and another requester with valid wins if it is next in order.
- Idle counter:
  - Counts GRANT cycles with no transfer.
  - Clears on any transfer and on entry to GRANT.
  - Width is $clog2(TIMEOUT+1) and it saturates.
  - When it reaches TIMEOUT-1 with no transfer in that cycle (TIMEOUT>0), go to IDLE and pulse timeout_pulse for 1 cycle.
  - The requester's partial message is abandoned; the arbiter sends no filler byte.
- Requester obligations:
  - Hold data and last stable while valid && !ready.
  - req_valid may rise at any time.
  - The arbiter never drops or duplicates an accepted byte.
- Simultaneous events:
  - A last-byte transfer in the same cycle the counter would expire counts as a transfer: normal release, no timeout_pulse.
  - New requests arriving during GRANT wait for IDLE.
- grant_id holds its value in IDLE and serves as the round-robin pointer.
- busy = (state==GRANT).
- Reset mid-message:
  - Immediate return to reset values.
  - Any in-flight byte not yet accepted is dropped.
  - The UART core is reset by the same reset.
- Downstream tx_ready high while tx_valid is low has no effect.

Test Plan:
- Single requester:
  - Stimulus: after reset, requester 0 sends 3 bytes 0x48,0x69,0x0A (last on 0x0A); tx_ready always 1.
  - Required: grant 1 cycle after req_valid; bytes appear on tx_data in order on 3 consecutive cycles; busy drops after the 0x0A edge.
- Contention:
  - Stimulus: requesters 0 and 1 both assert valid in the same cycle with 2-byte messages (0xA1,0xA2 and 0xB1,0xB2).
  - Required: tx sequence A1,A2,B1,B2 with no interleave; grant_id goes 0 then 1.
- Fairness:
  - Stimulus: both requesters continuously send 1-byte messages for 8 messages.
  - Required: grants alternate 0,1,0,1…, with exactly 4 messages each.
- Backpressure:
  - Stimulus: tx_ready low for 5 cycles mid-message with TIMEOUT=1024.
  - Required: byte held stable, no timeout_pulse, message completes intact.
- Timeout:
  - Stimulus: TIMEOUT=16; requester 1 sends 1 byte without last, then drops valid; requester 0 is pending.
  - Required: timeout_pulse exactly 16 idle cycles after the last transfer; requester 0 is then granted.
- Reset mid-message:
  - Stimulus: assert reset during byte 2 of 4.
  - Required: tx_valid=0, busy=0, grant_id=NREQ-1 asynchronously; after release, requester 0 is granted first.
